// File: rtl/cic_comp_fir.sv
// Time-multiplexed droop-compensation FIR that follows the CIC decimator.
// One MAC per clock walks the circular delay line newest-first, then the result is rounded and saturated.
module cic_comp_fir #(
  parameter int INP_DW  = 14,
  parameter int OUT_DW  = 16,
  parameter int COEF_DW = 18,
  parameter int TAPS    = 15,
  parameter int DECIM   = 1,
  parameter int SHIFT   = 14,
  localparam int AW     = $clog2(TAPS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic signed [INP_DW-1:0]  inp_samp_data,
  input  logic                      inp_samp_str,
  output logic signed [OUT_DW-1:0]  out_samp_data,
  output logic                      out_samp_str,
  output logic                      out_sat,
  output logic                      busy,
  output logic                      overrun,
  input  logic                      coef_we,
  input  logic [AW-1:0]             coef_addr,
  input  logic signed [COEF_DW-1:0] coef_data
);

  localparam int PW    = INP_DW + COEF_DW;
  localparam int ACC_W = INP_DW + COEF_DW + $clog2(TAPS);

  localparam logic signed [COEF_DW-1:0] UNITY = {2'b01, {(COEF_DW-2){1'b0}}};
  localparam logic signed [ACC_W:0] HALF = {{(ACC_W-SHIFT+1){1'b0}}, 1'b1, {(SHIFT-1){1'b0}}};
  localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(OUT_DW-1) - 1);
  localparam logic signed [ACC_W:0] MINV = (ACC_W+1)'(-(2**(OUT_DW-1)));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_t;

  state_t state_q, state_d;

  logic signed [INP_DW-1:0]  x_q    [TAPS];
  logic signed [COEF_DW-1:0] coef_q [TAPS];

  logic [AW-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, k_q, k_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic                      phase_q, phase_d;
  logic                      overrun_q, overrun_d;
  logic signed [OUT_DW-1:0]  y_q, y_d, out_data_q, out_data_d;
  logic                      ysat_q, ysat_d, out_sat_q, out_sat_d, out_str_q, out_str_d;

  logic                      accept, drop, cf_we;
  logic signed [PW-1:0]      prod;

  // Returns {saturated, y}: round half up, then clip to the output range.
  function automatic logic [OUT_DW:0] round_sat(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W:0] ext;
    logic signed [ACC_W:0] r;
    ext = {a[ACC_W-1], a};
    r   = (ext + HALF) >>> SHIFT;
    if (r > MAXV)      round_sat = {1'b1, MAXV[OUT_DW-1:0]};
    else if (r < MINV) round_sat = {1'b1, MINV[OUT_DW-1:0]};
    else               round_sat = {1'b0, r[OUT_DW-1:0]};
  endfunction

  // A strobe landing in OUT is accepted so back-to-back samples lose no cycle.
  assign accept = inp_samp_str && !clear && (state_q == S_IDLE || state_q == S_OUT);
  assign drop   = inp_samp_str && !clear && (state_q == S_MAC || state_q == S_ROUND);
  assign cf_we  = coef_we && !clear && !inp_samp_str && (state_q == S_IDLE)
                  && (int'(coef_addr) < TAPS);
  assign prod   = coef_q[k_q] * x_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    k_d        = k_q;
    acc_d      = acc_q;
    phase_d    = phase_q;
    overrun_d  = overrun_q;
    y_d        = y_q;
    ysat_d     = ysat_q;
    out_data_d = out_data_q;
    out_sat_d  = out_sat_q;
    out_str_d  = 1'b0;

    case (state_q)
      S_MAC: begin
        acc_d    = acc_q + ACC_W'(prod);
        k_d      = k_q + AW'(1);
        rd_ptr_d = (rd_ptr_q == '0) ? AW'(TAPS-1) : rd_ptr_q - AW'(1);
        if (k_q == AW'(TAPS-1)) state_d = S_ROUND;
      end
      S_ROUND: begin
        {ysat_d, y_d} = round_sat(acc_q);
        state_d       = S_OUT;
      end
      S_OUT: begin
        out_data_d = y_q;
        out_sat_d  = ysat_q;
        out_str_d  = 1'b1;
        state_d    = S_IDLE;
      end
      default: ;
    endcase

    if (accept) begin
      rd_ptr_d = wr_ptr_q;
      wr_ptr_d = (wr_ptr_q == AW'(TAPS-1)) ? '0 : wr_ptr_q + AW'(1);
      acc_d    = '0;
      k_d      = '0;
      phase_d  = (DECIM == 2) ? ~phase_q : 1'b0;
      if (!phase_q) state_d = S_MAC;
    end

    if (drop) overrun_d = 1'b1;

    if (clear) begin
      state_d   = S_IDLE;
      wr_ptr_d  = '0;
      k_d       = '0;
      acc_d     = '0;
      phase_d   = 1'b0;
      overrun_d = 1'b0;
      out_str_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      k_q        <= '0;
      acc_q      <= '0;
      phase_q    <= 1'b0;
      overrun_q  <= 1'b0;
      y_q        <= '0;
      ysat_q     <= 1'b0;
      out_data_q <= '0;
      out_sat_q  <= 1'b0;
      out_str_q  <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= (i == 0) ? UNITY : '0;
      end
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      k_q        <= k_d;
      acc_q      <= acc_d;
      phase_q    <= phase_d;
      overrun_q  <= overrun_d;
      y_q        <= y_d;
      ysat_q     <= ysat_d;
      out_data_q <= out_data_d;
      out_sat_q  <= out_sat_d;
      out_str_q  <= out_str_d;
      if (clear) begin
        for (int i = 0; i < TAPS; i++) x_q[i] <= '0;
      end else if (accept) begin
        x_q[wr_ptr_q] <= inp_samp_data;
      end
      if (cf_we) coef_q[coef_addr] <= coef_data;
    end
  end

  assign out_samp_data = out_data_q;
  assign out_samp_str  = out_str_q;
  assign out_sat       = out_sat_q;
  assign overrun       = overrun_q;
  assign busy          = (state_q == S_MAC) || (state_q == S_ROUND);

endmodule

// File: tb/tb_cic_comp_fir.sv
// Directed bench for cic_comp_fir: one DECIM=1 instance for most scenarios and a DECIM=2 instance for the rate check.
module tb_cic_comp_fir;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear = 1'b0;
  logic str = 1'b0;
  logic str2 = 1'b0;
  logic coef_we = 1'b0;
  logic signed [13:0] din = '0;
  logic [3:0] caddr = '0;
  logic signed [17:0] cdata = '0;

  logic signed [15:0] dout, dout2;
  logic ostr, osat, obusy, oovr;
  logic ostr2, osat2, obusy2, oovr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cic_comp_fir u_dut (
    .clk(clk), .reset(reset), .clear(clear),
    .inp_samp_data(din), .inp_samp_str(str),
    .out_samp_data(dout), .out_samp_str(ostr), .out_sat(osat),
    .busy(obusy), .overrun(oovr),
    .coef_we(coef_we), .coef_addr(caddr), .coef_data(cdata)
  );

  cic_comp_fir #(.DECIM(2)) u_dut2 (
    .clk(clk), .reset(reset), .clear(clear),
    .inp_samp_data(din), .inp_samp_str(str2),
    .out_samp_data(dout2), .out_samp_str(ostr2), .out_sat(osat2),
    .busy(obusy2), .overrun(oovr2),
    .coef_we(1'b0), .coef_addr(caddr), .coef_data(cdata)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic strobe(input int v);
    din = v[13:0];
    str = 1'b1;
    @(posedge clk); #1;
    str = 1'b0;
  endtask

  task automatic strobe2(input int v);
    din = v[13:0];
    str2 = 1'b1;
    @(posedge clk); #1;
    str2 = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit got);
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ostr) got = 1'b1;
    end
  endtask

  task automatic run(input int v, output int y, output logic s);
    int lat;
    bit got;
    strobe(v);
    wait_out(lat, got);
    if (!got) chk("run_timeout", 0, 1);
    y = dout;
    s = osat;
  endtask

  task automatic wr_coef(input int a, input int d);
    caddr = a[3:0];
    cdata = d[17:0];
    coef_we = 1'b1;
    @(posedge clk); #1;
    coef_we = 1'b0;
  endtask

  task automatic set_all(input int d);
    for (int i = 0; i < 15; i++) wr_coef(i, d);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic count_str(input int n, output int cnt, output int last);
    cnt = 0;
    last = dout;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (ostr) begin
        cnt++;
        last = dout;
      end
    end
  endtask

  initial begin
    int y, lat, cnt, last, nok;
    logic s;
    bit got;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", dout, 0);
    chk("rst_flags", {ostr, osat, obusy, oovr}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Default pass-through coefficients: unity on tap 0 gives 4x gain.
    strobe(1000);
    chk("busy_after_capture", obusy, 1);
    wait_out(lat, got);
    chk("latency", lat, 17);
    chk("imp_y0", dout, 4000);
    chk("imp_sat", osat, 0);
    @(posedge clk); #1;
    chk("str_single_cycle", ostr, 0);
    chk("data_holds", dout, 4000);
    run(0, y, s);
    chk("imp_y1", y, 0);

    // All taps at 16384 (unity/4): DC builds up to 15x input.
    set_all(16384);
    pulse_clear();
    for (int i = 0; i < 15; i++) begin
      run(100, y, s);
      if (i == 0) chk("dc_first", y, 100);
    end
    chk("dc_settle", y, 1500);

    pulse_clear();
    nok = 0;
    for (int i = 0; i < 15; i++) begin
      run((i == 0) ? 100 : 0, y, s);
      if (y == 100) nok++;
    end
    chk("imp16k_run", nok, 15);
    run(0, y, s);
    chk("imp16k_tail", y, 0);

    // All taps unity: full-scale DC saturates both ways.
    set_all(65536);
    pulse_clear();
    for (int i = 0; i < 15; i++) run(8191, y, s);
    chk("sat_pos", y, 32767);
    chk("sat_pos_flag", s, 1);
    for (int i = 0; i < 15; i++) run(-8192, y, s);
    chk("sat_neg", y, -32768);
    chk("sat_neg_flag", s, 1);

    // Rounding: coef[0]=2 puts the tap product exactly at +-half LSB.
    set_all(0);
    wr_coef(0, 2);
    pulse_clear();
    run(4096, y, s);
    chk("rnd_half_pos", y, 1);
    run(-4096, y, s);
    chk("rnd_half_neg", y, 0);
    run(4095, y, s);
    chk("rnd_below_half", y, 0);
    chk("rnd_sat", s, 0);
    run(-4097, y, s);
    chk("rnd_neg_over_half", y, -1);

    // Overrun: second strobe 5 clocks later is dropped; coef write while busy ignored.
    set_all(16384);
    pulse_clear();
    strobe(1000);
    repeat (4) @(posedge clk);
    #1;
    strobe(500);
    chk("ovr_busy", obusy, 1);
    chk("ovr_set", oovr, 1);
    wr_coef(0, 0);
    count_str(30, cnt, last);
    chk("ovr_single_out", cnt, 1);
    chk("ovr_y", last, 1000);
    run(200, y, s);
    chk("wr_busy_ignored", y, 1200);
    chk("ovr_sticky", oovr, 1);
    pulse_clear();
    chk("ovr_cleared", oovr, 0);
    run(100, y, s);
    chk("clear_delay_line", y, 100);

    // DECIM=2: ten input strobes give five outputs.
    cnt = 0;
    last = 0;
    for (int n = 0; n < 10; n++) begin
      strobe2(1000);
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        if (ostr2) begin
          cnt++;
          last = dout2;
        end
      end
    end
    chk("decim2_count", cnt, 5);
    chk("decim2_y", last, 4000);

    // Reset mid-MAC: outputs drop at once, no strobe, coefs back to pass-through.
    strobe(1000);
    repeat (5) @(posedge clk);
    #1;
    chk("pre_rst_busy", obusy, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_data", dout, 0);
    chk("rst_mid_flags", {ostr, osat, obusy, oovr}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    count_str(25, cnt, last);
    chk("rst_mid_no_str", cnt, 0);
    run(1000, y, s);
    chk("rst_coef_default", y, 4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
